serial_hba_bridge: RTL and testbench

Parametrised second-generation bridge from a UART byte stream to the HomeBrew Automation (HBA) bus. It parses the 2-byte command/register-address protocol, runs 1–8 byte burst transfers as an HBA master, and replies over serial. Additions over the first generation:
- real request/grant arbitration;
- a bus-transfer timeout with NACK;
- an inter-byte receive timeout;
- optional register-address auto-increment;
- peripheral interrupt aggregation.

It sits between the UART/send-receive byte layer and the HBA bus arbiter.

---
 rtl/hba_pkg.sv | 34 +++
 rtl/hba_master_ctl.sv | 126 ++++++++++++
 rtl/serial_hba_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_serial_hba_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hba_pkg.sv
// Shared types and constants for the serial-to-HBA bridge: FSM states,
// the command byte layout and the reply/fill byte values.
package hba_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_REG,
    ST_ECHO_CMD,
    ST_ECHO_REG,
    ST_GET_DATA,
    ST_BUS_REQ,
    ST_BUS_XFER,
    ST_SEND_DATA,
    ST_SEND_ACK
  } state_e;

  typedef enum logic [1:0] {
    M_IDLE,
    M_REQ,
    M_XFER
  } mstate_e;

  // Command byte: [7] rnw, [6:4] burst length minus one, [3:0] core.
  typedef struct packed {
    logic       rnw;
    logic [2:0] len;
    logic [3:0] core;
  } cmd_t;

  localparam logic [7:0] ACK_BYTE  = 8'hAC;
  localparam logic [7:0] NACK_BYTE = 8'h56;
  localparam logic [7:0] RD_FILL   = 8'hFF;

endpackage

// File: rtl/hba_master_ctl.sv
// HBA master handshake: request, wait for grant, drive one transfer, wait for ack or timeout.
// done pulses the cycle after ack/timeout; no timeout while waiting for grant.
module hba_master_ctl import hba_pkg::*; #(
  parameter int DBUS_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int XFER_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  rnw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DBUS_WIDTH-1:0] wdata,
  input  logic                  hba_mgrant,
  input  logic                  hba_xferack,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic                  master_request,
  output logic [ADDR_WIDTH-1:0] master_abus,
  output logic                  master_rnw,
  output logic                  master_select,
  output logic [DBUS_WIDTH-1:0] master_dbus,
  output logic                  done,
  output logic                  timeout,
  output logic [DBUS_WIDTH-1:0] rdata
);

  localparam int            CW    = $clog2(XFER_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(XFER_TIMEOUT);

  mstate_e               mst_q, mst_d;
  logic                  req_q, req_d;
  logic                  sel_q, sel_d;
  logic                  rnw_q, rnw_d;
  logic                  done_q, done_d;
  logic                  to_q, to_d;
  logic [ADDR_WIDTH-1:0] abus_q, abus_d;
  logic [DBUS_WIDTH-1:0] dbus_q, dbus_d;
  logic [DBUS_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  always_comb begin
    mst_d   = mst_q;
    req_d   = req_q;
    sel_d   = sel_q;
    rnw_d   = rnw_q;
    abus_d  = abus_q;
    dbus_d  = dbus_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    case (mst_q)
      M_IDLE: begin
        if (start) begin
          req_d = 1'b1;
          mst_d = M_REQ;
        end
      end
      M_REQ: begin
        if (hba_mgrant) begin
          sel_d  = 1'b1;
          rnw_d  = rnw;
          abus_d = addr;
          dbus_d = rnw ? '0 : wdata;
          cnt_d  = CW'(1);
          mst_d  = M_XFER;
        end
      end
      M_XFER: begin
        // cnt_q is the 1-based index of the current select cycle; an ack on the
        // last allowed cycle still counts as success.
        if (hba_xferack || cnt_q == LIMIT) begin
          req_d   = 1'b0;
          sel_d   = 1'b0;
          rnw_d   = 1'b0;
          abus_d  = '0;
          dbus_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          to_d    = !hba_xferack;
          rdata_d = hba_xferack ? hba_dbus : DBUS_WIDTH'(RD_FILL);
          mst_d   = M_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: mst_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_q   <= M_IDLE;
      req_q   <= 1'b0;
      sel_q   <= 1'b0;
      rnw_q   <= 1'b0;
      abus_q  <= '0;
      dbus_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      mst_q   <= mst_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      rnw_q   <= rnw_d;
      abus_q  <= abus_d;
      dbus_q  <= dbus_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  assign master_request = req_q;
  assign master_select  = sel_q;
  assign master_rnw     = rnw_q;
  assign master_abus    = abus_q;
  assign master_dbus    = dbus_q;
  assign done           = done_q;
  assign timeout        = to_q;
  assign rdata          = rdata_q;

endmodule

// File: rtl/serial_hba_bridge.sv
// UART byte stream to HBA master bridge: cmd/reg parse, 1-8 byte bursts, serial replies.
// Pops only on rx_valid with a gap cycle after each pop; sends only when tx_busy is low.
module serial_hba_bridge import hba_pkg::*; #(
  parameter int DBUS_WIDTH        = 8,
  parameter int PERIPH_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH    = 8,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int AUTO_INC          = 1,
  parameter int XFER_TIMEOUT      = 255,
  parameter int RX_TIMEOUT        = 1_000_000,
  parameter int NUM_INTR          = 16
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_rd,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_busy,
  input  logic                  hba_mgrant,
  input  logic                  hba_xferack,
  input  logic [DBUS_WIDTH-1:0] hba_dbus,
  output logic                  master_request,
  output logic [ADDR_WIDTH-1:0] master_abus,
  output logic                  master_rnw,
  output logic                  master_select,
  output logic [DBUS_WIDTH-1:0] master_dbus,
  input  logic [NUM_INTR-1:0]   periph_intr,
  output logic                  intr
);

  localparam int             RXW      = $clog2(RX_TIMEOUT + 1);
  localparam logic [RXW-1:0] RX_LIMIT = RXW'(RX_TIMEOUT - 1);

  state_e                    state_q, state_d;
  cmd_t                      cmd_q, cmd_d;
  logic [REG_ADDR_WIDTH-1:0] reg_q, reg_d;
  logic [2:0]                rem_q, rem_d;
  logic [DBUS_WIDTH-1:0]     wdata_q, wdata_d;
  logic                      err_q, err_d;
  logic [RXW-1:0]            rx_cnt_q, rx_cnt_d;
  logic                      pop_gap_q, pop_gap_d;
  logic                      tx_gap_q, tx_gap_d;
  logic                      intr_q, intr_d;

  logic                      pop, send, start, rx_expire, rx_wait;
  logic [7:0]                tx_byte;
  logic                      ctl_done, ctl_timeout;
  logic [DBUS_WIDTH-1:0]     ctl_rdata;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    reg_d     = reg_q;
    rem_d     = rem_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rx_cnt_d  = '0;
    start     = 1'b0;
    tx_byte   = 8'h00;
    intr_d    = |periph_intr;

    pop  = (state_q inside {ST_IDLE, ST_GET_REG, ST_GET_DATA}) && rx_valid &&
           !pop_gap_q && !hba_reset;
    send = (state_q inside {ST_ECHO_CMD, ST_ECHO_REG, ST_SEND_DATA, ST_SEND_ACK}) &&
           !tx_busy && !tx_gap_q && !hba_reset;
    pop_gap_d = pop;
    tx_gap_d  = send;

    // Inter-byte watchdog only runs while a command is partially received.
    rx_wait   = state_q inside {ST_GET_REG, ST_GET_DATA};
    rx_expire = rx_wait && !pop && (rx_cnt_q == RX_LIMIT);
    if (rx_wait && !pop) rx_cnt_d = rx_cnt_q + RXW'(1);

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cmd_d   = cmd_t'(rx_data);
          state_d = ST_GET_REG;
        end
      end
      ST_GET_REG: begin
        if (pop) begin
          reg_d   = rx_data[REG_ADDR_WIDTH-1:0];
          rem_d   = cmd_q.len;
          state_d = cmd_q.rnw ? ST_ECHO_CMD : ST_GET_DATA;
        end else if (rx_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_ECHO_CMD: begin
        tx_byte = cmd_q;
        if (send) state_d = ST_ECHO_REG;
      end
      ST_ECHO_REG: begin
        tx_byte = 8'(reg_q);
        if (send) state_d = ST_BUS_REQ;
      end
      ST_GET_DATA: begin
        if (pop) begin
          wdata_d = DBUS_WIDTH'(rx_data);
          state_d = ST_BUS_REQ;
        end else if (rx_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS_REQ: begin
        start = 1'b1;
        if (master_select) state_d = ST_BUS_XFER;
      end
      ST_BUS_XFER: begin
        if (ctl_done) begin
          if (AUTO_INC != 0) reg_d = reg_q + REG_ADDR_WIDTH'(1);
          if (!cmd_q.rnw && ctl_timeout) err_d = 1'b1;
          if (cmd_q.rnw) begin
            state_d = ST_SEND_DATA;
          end else if (rem_q == 3'd0) begin
            state_d = ST_SEND_ACK;
          end else begin
            rem_d   = rem_q - 3'd1;
            state_d = ST_GET_DATA;
          end
        end
      end
      ST_SEND_DATA: begin
        tx_byte = ctl_rdata[7:0];
        if (send) begin
          if (rem_q == 3'd0) begin
            state_d = ST_IDLE;
          end else begin
            rem_d   = rem_q - 3'd1;
            state_d = ST_BUS_REQ;
          end
        end
      end
      ST_SEND_ACK: begin
        tx_byte = err_q ? NACK_BYTE : ACK_BYTE;
        if (send) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE) err_d = 1'b0;
  end

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      reg_q     <= '0;
      rem_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rx_cnt_q  <= '0;
      pop_gap_q <= 1'b0;
      tx_gap_q  <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      reg_q     <= reg_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
      rx_cnt_q  <= rx_cnt_d;
      pop_gap_q <= pop_gap_d;
      tx_gap_q  <= tx_gap_d;
      intr_q    <= intr_d;
    end
  end

  hba_master_ctl #(
    .DBUS_WIDTH   (DBUS_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH),
    .XFER_TIMEOUT (XFER_TIMEOUT)
  ) u_master_ctl (
    .clk            (hba_clk),
    .rst            (hba_reset),
    .start          (start),
    .rnw            (cmd_q.rnw),
    .addr           ({cmd_q.core[PERIPH_ADDR_WIDTH-1:0], reg_q}),
    .wdata          (wdata_q),
    .hba_mgrant     (hba_mgrant),
    .hba_xferack    (hba_xferack),
    .hba_dbus       (hba_dbus),
    .master_request (master_request),
    .master_abus    (master_abus),
    .master_rnw     (master_rnw),
    .master_select  (master_select),
    .master_dbus    (master_dbus),
    .done           (ctl_done),
    .timeout        (ctl_timeout),
    .rdata          (ctl_rdata)
  );

  assign rx_rd   = pop;
  assign tx_wr   = send;
  assign tx_data = send ? tx_byte : 8'h00;
  assign intr    = intr_q;

endmodule

// File: tb/tb_serial_hba_bridge.sv
// Scoreboard bench for serial_hba_bridge: a command-level model queues expected
// serial replies and bus transfers; independent monitors pop and compare.
module tb_serial_hba_bridge;

  localparam int RX_T = 200;
  localparam int XT   = 255;

  typedef struct { int delay; logic [7:0] rdata; } plan_t;
  typedef struct { logic [11:0] addr; logic rnw; logic [7:0] dbus; int len; } bus_t;

  logic        hba_clk = 1'b0;
  logic        hba_reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_rd;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy = 1'b0;
  logic        hba_mgrant = 1'b0;
  logic        hba_xferack = 1'b0;
  logic [7:0]  hba_dbus = 8'h00;
  logic        master_request;
  logic [11:0] master_abus;
  logic        master_rnw;
  logic        master_select;
  logic [7:0]  master_dbus;
  logic [15:0] periph_intr = 16'h0000;
  logic        intr;

  int checks = 0;
  int errors = 0;

  plan_t      plan_q[$];
  bus_t       exp_bus[$];
  logic [7:0] exp_tx[$];
  logic [7:0] rx_q[$];
  logic [7:0] vbuf[8];

  bit    grant_en = 1'b1;
  bit    flush = 1'b0;
  bit    sel_prev = 1'b0;
  int    sel_len = 0;
  bus_t  cur;
  bit    rd_prev = 1'b0;
  bit    in_xfer = 1'b0;
  int    scnt = 0;
  plan_t rp;

  serial_hba_bridge #(.RX_TIMEOUT(RX_T)) dut (
    .hba_clk        (hba_clk),
    .hba_reset      (hba_reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_rd          (rx_rd),
    .tx_data        (tx_data),
    .tx_wr          (tx_wr),
    .tx_busy        (tx_busy),
    .hba_mgrant     (hba_mgrant),
    .hba_xferack    (hba_xferack),
    .hba_dbus       (hba_dbus),
    .master_request (master_request),
    .master_abus    (master_abus),
    .master_rnw     (master_rnw),
    .master_select  (master_select),
    .master_dbus    (master_dbus),
    .periph_intr    (periph_intr),
    .intr           (intr)
  );

  always #5 hba_clk = ~hba_clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Model: one command -> serial bytes to feed, expected bus transfers and replies.
  // dly >= 0: fixed ack delay; -1: every transfer times out; -2: random with rare timeouts.
  task automatic run_cmd(input bit rnw, input int n, input logic [3:0] core,
                         input logic [7:0] rg, input int dly);
    logic [7:0] cmd;
    bit         err;
    plan_t      p;
    bus_t       b;
    cmd = {rnw, 3'(n), core};
    err = 1'b0;
    rx_q.push_back(cmd);
    rx_q.push_back(rg);
    if (rnw) begin
      exp_tx.push_back(cmd);
      exp_tx.push_back(rg);
    end
    for (int i = 0; i <= n; i++) begin
      if (dly >= 0) p.delay = dly;
      else if (dly == -1) p.delay = -1;
      else p.delay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      p.rdata = rnw ? vbuf[i] : 8'($urandom);
      plan_q.push_back(p);
      b.addr = {core, rg + 8'(i)};
      b.rnw  = rnw;
      b.dbus = rnw ? 8'h00 : vbuf[i];
      b.len  = (p.delay < 0) ? XT : p.delay + 1;
      exp_bus.push_back(b);
      if (p.delay < 0) err = 1'b1;
      if (rnw) exp_tx.push_back((p.delay < 0) ? 8'hFF : p.rdata);
      else rx_q.push_back(vbuf[i]);
    end
    if (!rnw) exp_tx.push_back(err ? 8'h56 : 8'hAC);
  endtask

  task automatic wait_done(input string nm);
    int cyc;
    cyc = 0;
    while ((exp_tx.size() != 0 || rx_q.size() != 0 || exp_bus.size() != 0 ||
            master_select) && cyc < 20000) begin
      @(negedge hba_clk);
      cyc++;
    end
    chk({nm, "_complete"}, 32'(cyc < 20000), 32'd1);
    if (cyc >= 20000) begin
      exp_tx.delete(); rx_q.delete(); exp_bus.delete(); plan_q.delete();
    end
    repeat (3) @(negedge hba_clk);
  endtask

  task automatic check_quiet(input string nm);
    chk({nm, "_rx_rd"}, 32'(rx_rd), 0);
    chk({nm, "_tx_wr"}, 32'(tx_wr), 0);
    chk({nm, "_tx_data"}, 32'(tx_data), 0);
    chk({nm, "_req"}, 32'(master_request), 0);
    chk({nm, "_sel"}, 32'(master_select), 0);
    chk({nm, "_abus"}, 32'(master_abus), 0);
    chk({nm, "_dbus"}, 32'(master_dbus), 0);
    chk({nm, "_rnw"}, 32'(master_rnw), 0);
  endtask

  // Serial source: present queued bytes, retire one on each observed pop.
  always begin
    @(negedge hba_clk);
    if (!flush && rx_valid && rx_rd) begin
      chk("rx_rd_gap", 32'(rd_prev), 0);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
    rd_prev = rx_rd;
    @(posedge hba_clk); #1;
    rx_valid = (rx_q.size() != 0) && ($urandom_range(0, 3) != 0);
    rx_data  = rx_valid ? rx_q[0] : 8'h00;
  end

  always begin
    @(posedge hba_clk); #1;
    tx_busy = ($urandom_range(0, 2) == 0);
  end

  // Bus arbiter and slave: random grant latency, ack per the queued plan.
  always begin
    @(posedge hba_clk); #1;
    hba_mgrant  = grant_en && master_request && !master_select && ($urandom_range(0, 1) == 0);
    hba_xferack = 1'b0;
    hba_dbus    = 8'($urandom);
    if (master_select && !flush) begin
      if (!in_xfer) begin
        in_xfer = 1'b1;
        scnt = 0;
        if (plan_q.size() != 0) rp = plan_q.pop_front();
        else begin rp.delay = 0; rp.rdata = 8'h00; end
      end
      scnt++;
      if (rp.delay >= 0 && scnt == rp.delay + 1) begin
        hba_xferack = 1'b1;
        hba_dbus    = rp.rdata;
      end
    end else begin
      in_xfer = 1'b0;
    end
  end

  // Monitor: serial replies and bus transfers against the scoreboard.
  always @(negedge hba_clk) begin
    if (hba_reset || flush) begin
      sel_prev = 1'b0;
      sel_len  = 0;
    end else begin
      if (tx_wr) begin
        chk("tx_while_busy", 32'(tx_busy), 0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
        end else begin
          chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
        end
      end
      if (master_select && !sel_prev) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected actual=%0h required=none", master_abus);
          cur.addr = master_abus; cur.rnw = master_rnw; cur.dbus = master_dbus; cur.len = -1;
        end else begin
          cur = exp_bus.pop_front();
          chk("bus_rnw", 32'(master_rnw), 32'(cur.rnw));
          chk("bus_dbus", 32'(master_dbus), 32'(cur.dbus));
        end
        sel_len = 0;
      end
      if (master_select) begin
        sel_len++;
        chk("bus_abus", 32'(master_abus), 32'(cur.addr));
        chk("bus_req_held", 32'(master_request), 1);
      end else begin
        if (sel_prev) chk("sel_cycles", 32'(sel_len), 32'(cur.len));
        chk("abus_idle", 32'(master_abus), 0);
        chk("dbus_idle", 32'(master_dbus), 0);
      end
      sel_prev = master_select;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge hba_clk);
    @(negedge hba_clk);
    check_quiet("reset");
    chk("reset_intr", 32'(intr), 0);
    @(posedge hba_clk); #1;
    hba_reset = 1'b0;
    repeat (2) @(negedge hba_clk);

    vbuf[0] = 8'hA0; vbuf[1] = 8'hB1;
    run_cmd(1'b0, 1, 4'h2, 8'h05, 2);
    wait_done("wr_burst");

    vbuf[0] = 8'h11; vbuf[1] = 8'h22; vbuf[2] = 8'h33;
    run_cmd(1'b1, 2, 4'h3, 8'hFF, 1);
    wait_done("rd_burst_wrap");

    vbuf[0] = 8'h55;
    run_cmd(1'b0, 0, 4'h4, 8'h10, -1);
    wait_done("wr_timeout");

    run_cmd(1'b1, 0, 4'h4, 8'h10, -1);
    wait_done("rd_timeout");

    rx_q.push_back(8'h10);
    repeat (RX_T + 10) @(negedge hba_clk);
    chk("rx_timeout_consumed", 32'(rx_q.size()), 0);
    vbuf[0] = 8'h3C;
    run_cmd(1'b0, 0, 4'h1, 8'h22, 0);
    wait_done("after_rx_timeout");

    grant_en = 1'b0;
    vbuf[0] = 8'h5A;
    run_cmd(1'b0, 0, 4'h7, 8'h40, 1);
    c = 0;
    while (!master_request && c < 200) begin @(negedge hba_clk); c++; end
    chk("req_without_grant", 32'(master_request), 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge hba_clk);
      chk("no_sel_without_grant", 32'(master_select), 0);
    end
    grant_en = 1'b1;
    wait_done("grant_hold");

    for (int k = 0; k < 40; k++) begin
      bit         rnw;
      int         n;
      logic [7:0] rg;
      rnw = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(0, 7));
      rg  = (k % 5 == 0) ? 8'hFC : 8'($urandom);
      for (int i = 0; i < 8; i++) vbuf[i] = 8'($urandom);
      run_cmd(rnw, n, 4'($urandom), rg, -2);
      wait_done("random_cmd");
    end

    vbuf[0] = 8'h77;
    run_cmd(1'b0, 0, 4'h5, 8'h33, -1);
    c = 0;
    while (!master_select && c < 200) begin @(negedge hba_clk); c++; end
    chk("mid_xfer_sel", 32'(master_select), 1);
    repeat (10) @(negedge hba_clk);
    @(posedge hba_clk); #1;
    flush = 1'b1;
    hba_reset = 1'b1;
    exp_tx.delete(); rx_q.delete(); exp_bus.delete(); plan_q.delete();
    @(posedge hba_clk); #1;
    hba_reset = 1'b0;
    @(negedge hba_clk);
    check_quiet("mid_xfer_reset");
    repeat (2) @(negedge hba_clk);
    flush = 1'b0;
    vbuf[0] = 8'h9A; vbuf[1] = 8'hBC;
    run_cmd(1'b1, 1, 4'h6, 8'hFE, 0);
    wait_done("after_reset");

    @(posedge hba_clk); #1;
    periph_intr = 16'h0100;
    @(negedge hba_clk);
    chk("intr_before_edge", 32'(intr), 0);
    @(negedge hba_clk);
    chk("intr_set", 32'(intr), 1);
    @(posedge hba_clk); #1;
    periph_intr = 16'h0000;
    @(negedge hba_clk);
    chk("intr_hold", 32'(intr), 1);
    @(negedge hba_clk);
    chk("intr_clear", 32'(intr), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
